tagged_block_scheduler: RTL and testbench
=========================================

Name: tagged_block_scheduler

Overview:
- Synthesizable multi-flow input scheduler for the shared-accelerator input write port.
- Takes FLUX independent per-flow pixel streams and interleaves them onto one tagged write interface, one configured block (row) at a time.
- Selection is round-robin; exhausted, unconfigured and idle flows are skipped.
- Generalises the bench-side flow-feeding procedure into parametrised RTL with per-flow block length, per-flow total count and exact block accounting.

Parameters:
- FLUX, 4, number of flows; must be ≥2.
- DATA_W, 8, payload width per element.
- TAG_W, $clog2(FLUX), flow tag width.
- LEN_W, 8, block-length width.
- TOT_W, 16, per-flow total-element-count width.
- STALL_LIMIT, 16, stall cycles before skipping; used only with STALL_SKIP_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cfg_write  in  1  configuration strobe.
- cfg_flow  in  TAG_W  flow being configured.
- cfg_block_len  in  LEN_W  elements per block for that flow.
- cfg_total  in  TOT_W  total elements for that flow.
- cfg_err  out  1  one-cycle pulse when a config is rejected.
- src_valid  in  FLUX  per-flow element available.
- src_data  in  FLUX*DATA_W  per-flow element; flow i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  FLUX  per-flow element consumed this cycle.
- out_write  out  1  tagged write strobe to the accelerator.
- out_din  out  TAG_W+DATA_W  {tag, data}.
- out_full  in  FLUX  per-flow downstream full.
- flow_active  out  FLUX  flow has remaining elements.
- flow_done  out  FLUX  one-cycle pulse on the last element of a flow.

Behaviour:
- Reset (async, rst=1) clears all of the following:
  - Outputs: out_write=0, out_din=0, src_ready=0, cfg_err=0, flow_active=0, flow_done=0.
  - State: all per-flow registers; FSM=IDLE; rr pointer=FLUX-1, so flow 0 is considered first.
  - Reset mid-stream discards all progress.
- Per-flow registers: blk_len, remaining (TOT_W), blk_cnt (LEN_W).
- Configuration:
  - Accepted when cfg_write=1, flow inactive, cfg_block_len≠0 and cfg_total≠0.
  - On accept: blk_len←cfg_block_len, remaining←cfg_total, blk_cnt←0, flow_active bit set next cycle.
  - Otherwise, if cfg_write=1: cfg_err pulses next cycle and state is unchanged.
  - A config for a flow finishing in the same cycle is rejected, because the flow is still active when sampled.
- FSM:
  - IDLE: go to SELECT when any flow_active bit is set.
  - SELECT (1 cycle):
    - grant ← first active flow searching from rr+1 modulo FLUX; rr←grant; go to STREAM.
    - If no flow is active, go to IDLE.
  - STREAM:
    - src_ready[grant] = src_valid[grant] & ~out_full[grant] (combinational); all other src_ready bits are 0.
    - Transfer: out_write=src_ready[grant]; out_din={grant, src_data[grant]}. Combinational, zero latency.
    - Each transfer: remaining−1, blk_cnt+1.
    - Block ends when blk_cnt+1==blk_len (exactly blk_len elements, no extra element). blk_cnt←0, go to SELECT.
    - If remaining reaches 0 first: flow_done pulse, flow_active cleared, blk_cnt←0, go to SELECT. A partial final block is allowed.
    - Stall when out_full=1 or src_valid=0: remain in STREAM, no transfer.
- Exactly one flow is granted at a time. Out-of-turn out_full bits and src_valid bits for non-granted flows are ignored.
- Single active flow: the block is reselected after the SELECT bubble (1 idle cycle between blocks).

Optional Feature:
- Macro STALL_SKIP_EN.
- Defined:
  - A stall counter counts consecutive non-transfer STREAM cycles.
  - On reaching STALL_LIMIT, go to SELECT. The granted flow keeps its blk_cnt and resumes mid-block when next granted.
  - The counter clears on any transfer or grant change.
- Undefined: no counter; a stalled grant persists indefinitely.

Test Plan:
- Config flows 0..3 with block_len 71/39/23/15 and totals 5041/1521/529/225; all sources always valid; out_full=0.
  - Expected output tags: 71×tag0, 39×tag1, 23×tag2, 15×tag3, repeating.
  - Expected: each flow_done fires after exactly its total; elements per tag equal the totals; data order preserved per flow.
- Only flow 2 configured, block_len 4, total 10.
  - Expected: writes in runs 4,4,2 with one idle cycle between runs.
  - Expected: flow_done[2] pulse on the 10th write; FSM returns to IDLE.
- Hold out_full[1]=1 for 20 cycles while flow 1 is granted.
  - Expected: src_ready[1]=0 and out_write=0 throughout; no other flow is granted.
  - With STALL_SKIP_EN and STALL_LIMIT=16: flow 2 is granted after 16 cycles, and flow 1 later resumes with its residual block count.
- Config with cfg_block_len=0, or cfg_total=0, or to a currently active flow.
  - Expected: cfg_err pulse; the target flow's registers are unchanged.
- Assert rst mid-block (flow 0 at blk_cnt=30).
  - Expected: all outputs immediately 0; after release, flow_active=0 until reconfigured.
- Flow 3 total 7, block_len 15.
  - Expected: single partial block of 7; rotation continues to flow 0 with no lost or extra element.

Source files
------------

// File: rtl/tagged_block_scheduler.sv
// Round-robin scheduler interleaving FLUX per-flow streams onto one tagged write port, one block at a time.
// Optional build macro STALL_SKIP_EN: abandon a stalled grant after STALL_LIMIT idle STREAM cycles.
module tagged_block_scheduler #(
    parameter int FLUX        = 4,
    parameter int DATA_W      = 8,
    parameter int TAG_W       = $clog2(FLUX),
    parameter int LEN_W       = 8,
    parameter int TOT_W       = 16,
    parameter int STALL_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_write,
    input  logic [TAG_W-1:0]         cfg_flow,
    input  logic [LEN_W-1:0]         cfg_block_len,
    input  logic [TOT_W-1:0]         cfg_total,
    output logic                     cfg_err,
    input  logic [FLUX-1:0]          src_valid,
    input  logic [FLUX*DATA_W-1:0]   src_data,
    output logic [FLUX-1:0]          src_ready,
    output logic                     out_write,
    output logic [TAG_W+DATA_W-1:0]  out_din,
    input  logic [FLUX-1:0]          out_full,
    output logic [FLUX-1:0]          flow_active,
    output logic [FLUX-1:0]          flow_done
);

    if (FLUX < 2 || STALL_LIMIT < 1) begin : g_param_check
        $error("tagged_block_scheduler: FLUX must be >= 2 and STALL_LIMIT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_STREAM} state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   grant_q, grant_d;
    logic [TAG_W-1:0]   rr_q, rr_d;
    logic [LEN_W-1:0]   blk_len_q [FLUX];
    logic [LEN_W-1:0]   blk_len_d [FLUX];
    logic [LEN_W-1:0]   blk_cnt_q [FLUX];
    logic [LEN_W-1:0]   blk_cnt_d [FLUX];
    logic [TOT_W-1:0]   remaining_q [FLUX];
    logic [TOT_W-1:0]   remaining_d [FLUX];
    logic [FLUX-1:0]    active_q, active_d;
    logic               cfg_err_q, cfg_err_d;

    logic [DATA_W-1:0]  src_arr [FLUX];
    logic               xfer;
    logic               sel_found;
    logic [TAG_W-1:0]   sel_idx;
    logic               cfg_ok;

`ifdef STALL_SKIP_EN
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    for (genvar gi = 0; gi < FLUX; gi++) begin : g_src
        assign src_arr[gi] = src_data[gi*DATA_W +: DATA_W];
    end

    assign flow_active = active_q;
    assign cfg_err     = cfg_err_q;

    // First active flow strictly after the last grant, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= FLUX; k++) begin
            if (!sel_found && active_q[(int'(rr_q) + k) % FLUX]) begin
                sel_found = 1'b1;
                sel_idx   = TAG_W'((int'(rr_q) + k) % FLUX);
            end
        end
    end

    always_comb begin
        xfer      = (state_q == S_STREAM) && src_valid[grant_q] && !out_full[grant_q];
        src_ready = '0;
        src_ready[grant_q] = xfer;
        out_write = xfer;
        out_din   = (state_q == S_STREAM) ? {grant_q, src_arr[grant_q]} : '0;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        blk_len_d   = blk_len_q;
        blk_cnt_d   = blk_cnt_q;
        remaining_d = remaining_q;
        active_d    = active_q;
        cfg_err_d   = 1'b0;
        flow_done   = '0;
`ifdef STALL_SKIP_EN
        stall_d     = stall_q;
`endif

        // A flow finishing this cycle is still active here, so its reconfig is refused.
        cfg_ok = cfg_write && !active_q[cfg_flow] && (cfg_block_len != '0) && (cfg_total != '0);
        if (cfg_ok) begin
            blk_len_d[cfg_flow]   = cfg_block_len;
            remaining_d[cfg_flow] = cfg_total;
            blk_cnt_d[cfg_flow]   = '0;
            active_d[cfg_flow]    = 1'b1;
        end else if (cfg_write) begin
            cfg_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (|active_q) state_d = S_SELECT;
            end
            S_SELECT: begin
`ifdef STALL_SKIP_EN
                stall_d = '0;
`endif
                if (sel_found) begin
                    grant_d = sel_idx;
                    rr_d    = sel_idx;
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    remaining_d[grant_q] = remaining_q[grant_q] - TOT_W'(1);
                    blk_cnt_d[grant_q]   = blk_cnt_q[grant_q] + LEN_W'(1);
`ifdef STALL_SKIP_EN
                    stall_d = '0;
`endif
                    if (remaining_q[grant_q] == TOT_W'(1)) begin
                        flow_done[grant_q] = 1'b1;
                        active_d[grant_q]  = 1'b0;
                        blk_cnt_d[grant_q] = '0;
                        state_d            = S_SELECT;
                    end else if (blk_cnt_q[grant_q] + LEN_W'(1) == blk_len_q[grant_q]) begin
                        blk_cnt_d[grant_q] = '0;
                        state_d            = S_SELECT;
                    end
                end
`ifdef STALL_SKIP_EN
                else if (stall_q == STALL_W'(STALL_LIMIT - 1)) begin
                    // Give up the grant; blk_cnt is kept so the block resumes later.
                    stall_d = '0;
                    state_d = S_SELECT;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_q      <= TAG_W'(FLUX - 1);
            active_q  <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < FLUX; i++) begin
                blk_len_q[i]   <= '0;
                blk_cnt_q[i]   <= '0;
                remaining_q[i] <= '0;
            end
`ifdef STALL_SKIP_EN
            stall_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            active_q    <= active_d;
            cfg_err_q   <= cfg_err_d;
            blk_len_q   <= blk_len_d;
            blk_cnt_q   <= blk_cnt_d;
            remaining_q <= remaining_d;
`ifdef STALL_SKIP_EN
            stall_q     <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_tagged_block_scheduler.sv
// Directed bench for tagged_block_scheduler (default build): rotation, partial blocks, stalls, config rejects, reset.
module tb_tagged_block_scheduler;
    localparam int FLUX   = 4;
    localparam int DATA_W = 8;
    localparam int TAG_W  = 2;
    localparam int LEN_W  = 8;
    localparam int TOT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_write;
    logic [TAG_W-1:0]        cfg_flow;
    logic [LEN_W-1:0]        cfg_block_len;
    logic [TOT_W-1:0]        cfg_total;
    logic                    cfg_err;
    logic [FLUX-1:0]         src_valid;
    logic [FLUX*DATA_W-1:0]  src_data;
    logic [FLUX-1:0]         src_ready;
    logic                    out_write;
    logic [TAG_W+DATA_W-1:0] out_din;
    logic [FLUX-1:0]         out_full;
    logic [FLUX-1:0]         flow_active;
    logic [FLUX-1:0]         flow_done;

    int checks = 0;
    int errors = 0;
    int sent [FLUX] = '{default: 0};
    int exp_sent [FLUX] = '{default: 0};
    int exp_left [FLUX] = '{default: 0};
    int exp_q [$];
    logic [15:0] t2_pat;

    always #5 clk = ~clk;

    tagged_block_scheduler #(
        .FLUX(FLUX), .DATA_W(DATA_W), .TAG_W(TAG_W), .LEN_W(LEN_W), .TOT_W(TOT_W), .STALL_LIMIT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_write(cfg_write), .cfg_flow(cfg_flow), .cfg_block_len(cfg_block_len),
        .cfg_total(cfg_total), .cfg_err(cfg_err),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .out_write(out_write), .out_din(out_din), .out_full(out_full),
        .flow_active(flow_active), .flow_done(flow_done)
    );

    // Source i presents element number sent[i], value i*64+n modulo 256.
    for (genvar gi = 0; gi < FLUX; gi++) begin : g_src
        assign src_data[gi*DATA_W +: DATA_W] = DATA_W'(gi * 64 + sent[gi]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < FLUX; i++)
            if (src_ready[i]) sent[i] <= sent[i] + 1;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic cfg(input int f, input int len, input int tot);
        cfg_write     = 1'b1;
        cfg_flow      = TAG_W'(f);
        cfg_block_len = LEN_W'(len);
        cfg_total     = TOT_W'(tot);
        @(posedge clk); #1;
        cfg_write     = 1'b0;
    endtask

    task automatic quiet(input string name, input int n, input logic [3:0] act);
        repeat (n) begin
            #1;
            chk({name, "_wr"}, 32'(out_write), 32'd0);
            chk({name, "_act"}, 32'(flow_active), 32'(act));
            @(posedge clk); #1;
        end
    endtask

    // Pops one expected tag per observed write; checks tag, per-flow data order and done pulse.
    task automatic run_expect(input string name, input int max_cyc);
        int c;
        int t;
        logic [31:0] e;
        c = 0;
        while (exp_q.size() != 0 && c < max_cyc) begin
            #1;
            if (out_write) begin
                t = exp_q.pop_front();
                e = 32'({TAG_W'(t), DATA_W'(t * 64 + exp_sent[t])});
                chk({name, "_din"}, 32'(out_din), e);
                chk({name, "_done"}, 32'(flow_done), (exp_left[t] == 1) ? (32'd1 << t) : 32'd0);
                exp_left[t]--;
                exp_sent[t]++;
            end else begin
                chk({name, "_done_quiet"}, 32'(flow_done), 32'd0);
            end
            c++;
            @(posedge clk); #1;
        end
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_write = 1'b0; cfg_flow = '0; cfg_block_len = '0; cfg_total = '0;
        src_valid = 4'hF; out_full = '0;
        @(posedge clk); #2;
        chk("rst_wr", 32'(out_write), 0);
        chk("rst_din", 32'(out_din), 0);
        chk("rst_rdy", 32'(src_ready), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_act", 32'(flow_active), 0);
        chk("rst_done", 32'(flow_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        src_valid = 4'h0;
        @(posedge clk); #1;

        // Four flows, square totals: tags 71x0, 39x1, 23x2, 15x3 per round, exhausted flows drop out.
        cfg(0, 71, 5041);
        cfg(1, 39, 1521);
        cfg(2, 23, 529);
        cfg(3, 15, 225);
        exp_left = '{5041, 1521, 529, 225};
        exp_sent = sent;
        #1;
        chk("t1_active", 32'(flow_active), 32'hF);
        chk("t1_novalid", 32'(out_write), 0);
        src_valid = 4'hF;
        for (int r = 0; r < 71; r++) begin
            if (r < 71) repeat (71) exp_q.push_back(0);
            if (r < 39) repeat (39) exp_q.push_back(1);
            if (r < 23) repeat (23) exp_q.push_back(2);
            if (r < 15) repeat (15) exp_q.push_back(3);
        end
        run_expect("t1", 9000);
        quiet("t1_end", 3, 4'h0);

        // Lone flow 2, block 4 total 10: IDLE, SELECT, 4 writes, bubble, 4 writes, bubble, 2 writes.
        cfg(2, 4, 10);
        t2_pat = 16'h37BC;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("t2_wr", 32'(out_write), 32'(t2_pat[i]));
            chk("t2_done", 32'(flow_done), (i == 13) ? 32'd4 : 32'd0);
            @(posedge clk); #1;
        end
        chk("t2_active", 32'(flow_active), 0);

        // Config rejects while flow 1 sits granted with no valid data.
        src_valid = 4'b1101;
        cfg(1, 3, 6);
        exp_left[1] = 6;
        #1;
        chk("t4_ok_err", 32'(cfg_err), 0);
        cfg(1, 5, 9);
        #1;
        chk("t4_active_err", 32'(cfg_err), 1);
        cfg(0, 0, 5);
        #1;
        chk("t4_len0_err", 32'(cfg_err), 1);
        cfg(0, 4, 0);
        #1;
        chk("t4_tot0_err", 32'(cfg_err), 1);
        chk("t4_active", 32'(flow_active), 32'h2);
        @(posedge clk); #2;
        chk("t4_err_pulse", 32'(cfg_err), 0);
        chk("t4_stalled", 32'(out_write), 0);
        #1;
        exp_sent = sent;
        src_valid = 4'hF;
        repeat (6) exp_q.push_back(1);
        run_expect("t4", 40);

        // Reset in the middle of flow 0's first block.
        cfg(0, 71, 5041);
        exp_left[0] = 5041;
        exp_sent = sent;
        repeat (30) exp_q.push_back(0);
        run_expect("t5", 60);
        rst = 1'b1;
        #1;
        chk("t5_wr", 32'(out_write), 0);
        chk("t5_din", 32'(out_din), 0);
        chk("t5_rdy", 32'(src_ready), 0);
        chk("t5_act", 32'(flow_active), 0);
        chk("t5_done", 32'(flow_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        quiet("t5_post", 4, 4'h0);

        // Flow 3 partial block of 7, then rotation moves on to flow 0 (4 then 1).
        cfg(3, 15, 7);
        exp_left[3] = 7;
        quiet("t6_idle", 1, 4'h8);
        cfg(0, 4, 5);
        exp_left[0] = 5;
        exp_sent = sent;
        repeat (7) exp_q.push_back(3);
        repeat (5) exp_q.push_back(0);
        run_expect("t6", 40);
        quiet("t6_end", 2, 4'h0);

        // Downstream full on flow 1 for 20 cycles mid-block: nothing moves, flow 2 waits.
        cfg(1, 8, 16);
        cfg(2, 4, 4);
        exp_left[1] = 16;
        exp_left[2] = 4;
        exp_sent = sent;
        repeat (3) exp_q.push_back(1);
        run_expect("t3a", 20);
        out_full = 4'b0010;
        repeat (20) begin
            #1;
            chk("t3_rdy", 32'(src_ready), 0);
            chk("t3_wr", 32'(out_write), 0);
            @(posedge clk); #1;
        end
        out_full = '0;
        repeat (5) exp_q.push_back(1);
        repeat (4) exp_q.push_back(2);
        repeat (8) exp_q.push_back(1);
        run_expect("t3b", 40);
        quiet("t3_end", 2, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
